sobel_window_gen: RTL and testbench

//   Producer side of the 3x3 window interface consumed by the Sobel convolution stage.

---
 rtl/sobel_window_gen_if.sv | 36 +++
 rtl/sobel_window_gen.sv | 153 +++++++++++++++
 tb/tb_sobel_window_gen.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_gen_if.sv
// ---------------------------------------------------------------------------
// sobel_window_gen_if
//   Stream bundle between a raster pixel source and the 3x3 window generator.
//   Signals:
//     i_pixel_data        8   raster-order pixel, unsigned
//     i_pixel_data_valid  1   pixel qualifier (no backpressure)
//     o_pixel_data        72  3x3 window, byte k = row k/3, column k%3
//     o_pixel_data_valid  1   one-cycle window qualifier
//     o_frame_done        1   one-cycle pulse after the last pixel of a frame
//   Modports:
//     master  pixel source / window consumer side (drives i_*, samples o_*)
//     slave   window generator side (samples i_*, drives o_*)
// ---------------------------------------------------------------------------
interface sobel_window_gen_if;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_frame_done;

    modport master (
        output i_pixel_data,
        output i_pixel_data_valid,
        input  o_pixel_data,
        input  o_pixel_data_valid,
        input  o_frame_done
    );

    modport slave (
        input  i_pixel_data,
        input  i_pixel_data_valid,
        output o_pixel_data,
        output o_pixel_data_valid,
        output o_frame_done
    );
endinterface

// File: rtl/sobel_window_gen.sv
// ---------------------------------------------------------------------------
// sobel_window_gen
//   Builds 3x3 neighbourhoods from a raster-order 8-bit pixel stream using two
//   line buffers (rows r-2 and r-1) and a small shift window. One 72-bit window
//   is emitted per fully-interior position, one cycle after the pixel that
//   completes it; image borders are not padded.
//   Ports:
//     i_clk    clock, all logic on the rising edge
//     i_rstn   asynchronous active-low reset
//     i_clear  synchronous frame abort (wins over a same-cycle pixel)
//     pix_if   slave side of sobel_window_gen_if (pixel in, window out)
//   Parameters:
//     IMG_WIDTH  pixels per line (>= 3)
//     IMG_HEIGHT lines per frame (>= 3)
// ---------------------------------------------------------------------------
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_clear,
    sobel_window_gen_if.slave   pix_if
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] COL_FIRST_WIN = CW'(2);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FILL_LAST = RW'(1);

    typedef enum logic {
        FILL   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   col_reg, col_next;
    logic [RW-1:0]   row_reg, row_next;

    logic            accept;
    logic            col_wrap;
    logic            frame_end;
    logic            emit;
    logic            done_next;

    // Line buffers: lb1 holds row r-1, lb0 holds row r-2 at the current column.
    logic [7:0]      lb0 [IMG_WIDTH];
    logic [7:0]      lb1 [IMG_WIDTH];

    // Two most recent window columns per row: [2*row] older, [2*row+1] newer.
    logic [7:0]      hist_reg [6];
    logic [7:0]      new_col  [3];
    logic [7:0]      win_next [9];
    logic [71:0]     win_flat;

    logic [71:0]     data_reg;
    logic            valid_reg;
    logic            done_reg;

    assign accept    = pix_if.i_pixel_data_valid & ~i_clear;
    assign col_wrap  = (col_reg == COL_LAST);
    assign frame_end = col_wrap && (row_reg == ROW_LAST);
    // ACTIVE already implies row >= 2, so only the column needs checking.
    assign emit      = accept && (state_reg == ACTIVE) && (col_reg >= COL_FIRST_WIN);
    assign done_next = accept && (state_reg == ACTIVE) && frame_end;

    // New right-hand column, top to bottom: row r-2, row r-1, incoming pixel.
    // Reads see the old line-buffer contents; the writes below land at the edge.
    assign new_col[0] = lb0[col_reg];
    assign new_col[1] = lb1[col_reg];
    assign new_col[2] = pix_if.i_pixel_data;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
            assign win_next[gi*3 + 0] = hist_reg[gi*2 + 0];
            assign win_next[gi*3 + 1] = hist_reg[gi*2 + 1];
            assign win_next[gi*3 + 2] = new_col[gi];
        end
        for (genvar gi = 0; gi < 9; gi++) begin : g_win_pack
            assign win_flat[gi*8 +: 8] = win_next[gi];
        end
    endgenerate

    // Raster position counters.
    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (i_clear) begin
            col_next = '0;
            row_next = '0;
        end else if (accept) begin
            if (col_wrap) begin
                col_next = '0;
                row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (i_clear) begin
            state_next = FILL;
        end else if (accept) begin
            case (state_reg)
                FILL:    if (col_wrap && (row_reg == ROW_FILL_LAST)) state_next = ACTIVE;
                ACTIVE:  if (frame_end) state_next = FILL;
                default: state_next = FILL;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= FILL;
            col_reg   <= '0;
            row_reg   <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
            row_reg   <= row_next;
            valid_reg <= emit;
            done_reg  <= done_next;
            if (emit) begin
                data_reg <= win_flat;
            end
        end
    end

    // Storage without reset: stale contents are never exposed because windows
    // are only emitted once two full lines and two in-row columns are present.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb0[col_reg] <= lb1[col_reg];
            lb1[col_reg] <= pix_if.i_pixel_data;
            for (int i = 0; i < 3; i++) begin
                hist_reg[i*2 + 0] <= hist_reg[i*2 + 1];
                hist_reg[i*2 + 1] <= new_col[i];
            end
        end
    end

    assign pix_if.o_pixel_data       = data_reg;
    assign pix_if.o_pixel_data_valid = valid_reg;
    assign pix_if.o_frame_done       = done_reg;

endmodule

// File: tb/tb_sobel_window_gen.sv
// ---------------------------------------------------------------------------
// tb_sobel_window_gen
//   Directed sequence with randomized pixels and gaps on a 5x5 and a 3x3
//   instance. Expected windows come from a frame image held in the bench:
//   each window is read straight out of that image around the pixel position.
// ---------------------------------------------------------------------------
module tb_sobel_window_gen;
    logic clk;
    logic rstn;
    logic clr5;
    logic clr3;

    sobel_window_gen_if bus5 ();
    sobel_window_gen_if bus3 ();

    sobel_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(5)) dut5 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_clear(clr5),
        .pix_if (bus5)
    );

    sobel_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .i_clk  (clk),
        .i_rstn (rstn),
        .i_clear(clr3),
        .pix_if (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [71:0] WIN_A = 72'h16_15_14_0C_0B_0A_02_01_00;
    localparam logic [71:0] WIN_B = 72'h7A_79_78_70_6F_6E_66_65_64;

    int unsigned total;
    int unsigned passed;

    // Reference model state, index 0 = 5x5 instance, 1 = 3x3 instance.
    int          wd [2];
    int          ht [2];
    int          mr [2];
    int          mc [2];
    logic [7:0]  img [2][5][5];
    logic [71:0] last_data [2];
    int          win_cnt [2];
    int          done_cnt [2];
    logic [71:0] first_win [2];
    bit          first_seen [2];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: drive inputs on instance s, idle the other, then check.
    task automatic step(input int s, input bit v, input bit clr, input logic [7:0] pix);
        logic        exp_v;
        logic        exp_d;
        logic [71:0] w;
        logic        obs_v;
        logic        obs_d;
        logic [71:0] obs_data;
        if (s == 0) begin
            bus5.i_pixel_data_valid = v;   bus5.i_pixel_data = pix; clr5 = clr;
            bus3.i_pixel_data_valid = 1'b0; clr3 = 1'b0;
        end else begin
            bus3.i_pixel_data_valid = v;   bus3.i_pixel_data = pix; clr3 = clr;
            bus5.i_pixel_data_valid = 1'b0; clr5 = 1'b0;
        end
        @(posedge clk);
        #1;
        exp_v = 1'b0;
        exp_d = 1'b0;
        if (clr) begin
            mr[s] = 0;
            mc[s] = 0;
        end else if (v) begin
            img[s][mr[s]][mc[s]] = pix;
            if (mr[s] >= 2 && mc[s] >= 2) begin
                exp_v = 1'b1;
                w = '0;
                for (int k = 0; k < 9; k++)
                    w[k*8 +: 8] = img[s][mr[s] - 2 + k/3][mc[s] - 2 + k%3];
                last_data[s] = w;
            end
            exp_d = (mr[s] == ht[s] - 1) && (mc[s] == wd[s] - 1);
            mc[s]++;
            if (mc[s] == wd[s]) begin
                mc[s] = 0;
                mr[s]++;
                if (mr[s] == ht[s]) mr[s] = 0;
            end
        end
        if (s == 0) begin
            obs_v = bus5.o_pixel_data_valid; obs_d = bus5.o_frame_done; obs_data = bus5.o_pixel_data;
        end else begin
            obs_v = bus3.o_pixel_data_valid; obs_d = bus3.o_frame_done; obs_data = bus3.o_pixel_data;
        end
        chk($sformatf("valid[%0d]", s), {71'd0, obs_v}, {71'd0, exp_v});
        chk($sformatf("frame_done[%0d]", s), {71'd0, obs_d}, {71'd0, exp_d});
        chk($sformatf("data[%0d]", s), obs_data, last_data[s]);
        if (obs_v) begin
            win_cnt[s]++;
            if (!first_seen[s]) begin
                first_seen[s] = 1'b1;
                first_win[s]  = obs_data;
            end
        end
        if (obs_d) done_cnt[s]++;
    endtask

    // Full frame from the model's current position (expected to be 0,0).
    task automatic run_frame(input int s, input int base, input bit rnd, input bit gaps,
                             input bit chk_first, input logic [71:0] exp_first);
        logic [7:0] pix;
        win_cnt[s]    = 0;
        done_cnt[s]   = 0;
        first_seen[s] = 1'b0;
        for (int r = 0; r < ht[s]; r++) begin
            for (int c = 0; c < wd[s]; c++) begin
                pix = rnd ? 8'($urandom) : 8'(base + 10*r + c);
                if (gaps) begin
                    while ($urandom_range(0, 2) == 0) step(s, 1'b0, 1'b0, 8'($urandom));
                end
                step(s, 1'b1, 1'b0, pix);
            end
        end
        chk($sformatf("window_count[%0d]", s), 72'(win_cnt[s]), 72'((wd[s] - 2) * (ht[s] - 2)));
        chk($sformatf("done_count[%0d]", s), 72'(done_cnt[s]), 72'd1);
        if (chk_first) chk($sformatf("first_window[%0d]", s), first_win[s], exp_first);
    endtask

    // Raster pixels 10*r+c up to (sr,sc); that last pixel carries i_clear if clr.
    task automatic partial(input int s, input int sr, input int sc, input bit clr);
        for (int r = 0; r < ht[s]; r++) begin
            for (int c = 0; c < wd[s]; c++) begin
                if (r == sr && c == sc) begin
                    step(s, 1'b1, clr, 8'(10*r + c));
                    return;
                end
                step(s, 1'b1, 1'b0, 8'(10*r + c));
            end
        end
    endtask

    task automatic pulse_reset();
        bus5.i_pixel_data_valid = 1'b0;
        bus3.i_pixel_data_valid = 1'b0;
        clr5 = 1'b0;
        clr3 = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_valid[0]", {71'd0, bus5.o_pixel_data_valid}, 72'd0);
        chk("rst_done[0]",  {71'd0, bus5.o_frame_done}, 72'd0);
        chk("rst_data[0]",  bus5.o_pixel_data, 72'd0);
        chk("rst_valid[1]", {71'd0, bus3.o_pixel_data_valid}, 72'd0);
        chk("rst_done[1]",  {71'd0, bus3.o_frame_done}, 72'd0);
        chk("rst_data[1]",  bus3.o_pixel_data, 72'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int s = 0; s < 2; s++) begin
            mr[s] = 0;
            mc[s] = 0;
            last_data[s] = '0;
        end
    endtask

    initial begin
        total  = 0;
        passed = 0;
        wd[0] = 5; ht[0] = 5;
        wd[1] = 3; ht[1] = 3;
        for (int s = 0; s < 2; s++) begin
            mr[s] = 0; mc[s] = 0; last_data[s] = '0;
            win_cnt[s] = 0; done_cnt[s] = 0; first_seen[s] = 1'b0; first_win[s] = '0;
        end
        rstn = 1'b0;
        clr5 = 1'b0;
        clr3 = 1'b0;
        bus5.i_pixel_data = '0; bus5.i_pixel_data_valid = 1'b0;
        bus3.i_pixel_data = '0; bus3.i_pixel_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state on both instances.
        pulse_reset();

        // Continuous frame 10*r+c.
        run_frame(0, 0, 1'b0, 1'b0, 1'b1, WIN_A);
        // Same frame with random gaps, back to back with the previous one.
        run_frame(0, 0, 1'b0, 1'b1, 1'b1, WIN_A);
        // Back-to-back frame with offset data: no leak from the previous frame.
        run_frame(0, 100, 1'b0, 1'b0, 1'b1, WIN_B);
        // Random pixels with random gaps.
        run_frame(0, 0, 1'b1, 1'b1, 1'b0, '0);

        // Clear with a pixel at (3,1), then a fresh frame.
        partial(0, 3, 1, 1'b1);
        step(0, 1'b0, 1'b0, 8'hEE);
        run_frame(0, 0, 1'b0, 1'b0, 1'b1, WIN_A);
        // Clear on a window-producing pixel (2,2): window must be suppressed.
        partial(0, 2, 2, 1'b1);
        run_frame(0, 0, 1'b0, 1'b1, 1'b1, WIN_A);

        // Asynchronous reset mid-row 3 while a window is being presented.
        partial(0, 3, 3, 1'b0);
        pulse_reset();
        run_frame(0, 0, 1'b0, 1'b0, 1'b1, WIN_A);

        // Minimum image size: exactly one window, coincident with frame_done.
        run_frame(1, 0, 1'b0, 1'b0, 1'b1, WIN_A);
        run_frame(1, 0, 1'b1, 1'b1, 1'b0, '0);
        run_frame(1, 100, 1'b0, 1'b1, 1'b1, WIN_B);

        step(0, 1'b0, 1'b0, 8'h00);
        step(1, 1'b0, 1'b0, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
